// File: rtl/nice_stream_pkg.sv
// Shared types and header layout for the host-bound framed stream.
package nice_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_SYNC   = 2'd3
    } frame_state_e;

    localparam logic [7:0] HEADER_MAGIC_DEF = 8'hA5;

    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_MASK_LSB  = 16;
    localparam int HDR_FRAME_LSB = 0;

endpackage

// File: rtl/next_channel_sel.sv
// Priority encoder: lowest set mask bit strictly above cur_idx_i, or the
// lowest set bit overall when from_first_i is high.
module next_channel_sel #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [IDX_W-1:0]  cur_idx_i,
    input  logic              from_first_i,
    output logic [IDX_W-1:0]  next_idx_o,
    output logic              none_left_o
);

    always_comb begin
        next_idx_o  = '0;
        none_left_o = 1'b1;
        // Scan downwards so the final hit is the lowest qualifying bit.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_first_i || (i > int'(cur_idx_i)))) begin
                next_idx_o  = IDX_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/output_frame_sequencer.sv
// Snapshots all channels plus the sync word on a sample strobe and streams
// them as a header / data / sync framed packet on a valid-ready interface.
//
//   state     | meaning
//   ST_IDLE   | no frame; waiting for an enabled strobe
//   ST_HEADER | presenting the header word
//   ST_DATA   | presenting snapshot of channel ch_idx_q
//   ST_SYNC   | presenting the sync snapshot with last
module output_frame_sequencer
    import nice_stream_pkg::*;
#(
    parameter int         NUM_CH       = 8,
    parameter int         DATA_W       = 32,
    parameter logic [7:0] HEADER_MAGIC = HEADER_MAGIC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [NUM_CH-1:0]        ch_mask_i,
    input  logic                     sample_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [DATA_W-1:0]        sync_i,
    output logic [DATA_W-1:0]        m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o,
    output logic                     busy_o,
    output logic [15:0]              frame_cnt_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    frame_state_e              state_q, state_d;
    logic [IDX_W-1:0]          ch_idx_q, ch_idx_d;
    logic [NUM_CH*DATA_W-1:0]  snap_data_q;
    logic [DATA_W-1:0]         snap_sync_q;
    logic [NUM_CH-1:0]         snap_mask_q;
    logic [DATA_W-1:0]         m_data_q, m_data_d;
    logic                      m_valid_q, m_valid_d;
    logic                      m_last_q, m_last_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    logic                      hs, strobe, capture;
    logic [IDX_W-1:0]          next_idx;
    logic                      none_left;
    logic [DATA_W-1:0]         header_word;

    assign hs      = m_valid_q & m_ready_i;
    assign strobe  = sample_valid_i & enable_i;
    assign capture = strobe & ((state_q == ST_IDLE) | ((state_q == ST_SYNC) & hs));

    next_channel_sel #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_sel (
        .mask_i       (snap_mask_q),
        .cur_idx_i    (ch_idx_q),
        .from_first_i (state_q == ST_HEADER),
        .next_idx_o   (next_idx),
        .none_left_o  (none_left)
    );

    // Header is built from live inputs since the snapshot loads on the same edge.
    always_comb begin
        header_word                          = '0;
        header_word[HDR_MAGIC_LSB +: 8]      = HEADER_MAGIC;
        header_word[HDR_MASK_LSB +: 8]       = 8'(ch_mask_i);
        header_word[HDR_FRAME_LSB +: 16]     = frame_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            ST_IDLE: ;
            ST_HEADER, ST_DATA: begin
                if (hs) begin
                    if (none_left) begin
                        state_d  = ST_SYNC;
                        m_data_d = snap_sync_q;
                        m_last_d = 1'b1;
                    end else begin
                        state_d  = ST_DATA;
                        ch_idx_d = next_idx;
                        m_data_d = snap_data_q[int'(next_idx)*DATA_W +: DATA_W];
                    end
                end
            end
            ST_SYNC: begin
                if (hs) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            state_d     = ST_HEADER;
            m_data_d    = header_word;
            m_valid_d   = 1'b1;
            m_last_d    = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (strobe && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ch_idx_q    <= '0;
            snap_data_q <= '0;
            snap_sync_q <= '0;
            snap_mask_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            if (capture) begin
                snap_data_q <= ch_data_i;
                snap_sync_q <= sync_i;
                snap_mask_q <= ch_mask_i;
            end
        end
    end

    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;
    assign m_last_o    = m_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_output_frame_sequencer.sv
// Directed self-checking bench for output_frame_sequencer.
module tb_output_frame_sequencer;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;

    logic                     clk;
    logic                     rst_ni;
    logic                     enable_i;
    logic [NUM_CH-1:0]        ch_mask_i;
    logic                     sample_valid_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_i;
    logic [DATA_W-1:0]        sync_i;
    logic [DATA_W-1:0]        m_data_o;
    logic                     m_valid_o;
    logic                     m_ready_i;
    logic                     m_last_o;
    logic                     busy_o;
    logic [15:0]              frame_cnt_o;
    logic [15:0]              drop_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] words [0:31];
    logic              lasts [0:31];

    output_frame_sequencer #(
        .NUM_CH       (NUM_CH),
        .DATA_W       (DATA_W),
        .HEADER_MAGIC (8'hA5)
    ) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .ch_mask_i      (ch_mask_i),
        .sample_valid_i (sample_valid_i),
        .ch_data_i      (ch_data_i),
        .sync_i         (sync_i),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_last_o       (m_last_o),
        .busy_o         (busy_o),
        .frame_cnt_o    (frame_cnt_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        enable_i       = 1'b1;
        sample_valid_i = 1'b0;
        m_ready_i      = 1'b1;
        ch_mask_i      = '0;
        sync_i         = 32'h1234;
        for (int i = 0; i < NUM_CH; i++) ch_data_i[i*DATA_W +: DATA_W] = 32'h100 + i;
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic pulse_strobe();
        sample_valid_i = 1'b1;
        step();
        sample_valid_i = 1'b0;
    endtask

    // Collects one frame; stall_mode 1 deasserts ready on a fixed pattern.
    task automatic collect(input int stall_mode, output int n, output int span,
                           output int stall_bad, output bit timed_out);
        logic [DATA_W-1:0] sd;
        logic              sl;
        bit                stalled;
        bit                done;
        n = 0; span = 0; stall_bad = 0; timed_out = 1'b1; done = 1'b0;
        sd = '0; sl = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            m_ready_i = (stall_mode == 1) ? ((cyc % 3) != 1) : 1'b1;
            stalled = m_valid_o && !m_ready_i;
            if (m_valid_o && m_ready_i) begin
                if (n < 32) begin
                    words[n] = m_data_o;
                    lasts[n] = m_last_o;
                end
                n++;
                if (m_last_o) begin
                    done = 1'b1;
                    timed_out = 1'b0;
                end
            end else if (stalled) begin
                sd = m_data_o;
                sl = m_last_o;
            end
            step();
            span++;
            if (stalled && (!m_valid_o || m_data_o !== sd || m_last_o !== sl)) stall_bad++;
        end
        m_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        do_reset();
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", m_valid_o); end
        checks++; if (m_last_o !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", m_last_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", m_data_o); end
        checks++; if (frame_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_frame_cnt got=%h want=0", frame_cnt_o); end
        checks++; if (drop_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_drop_cnt got=%h want=0", drop_cnt_o); end
    endtask

    task automatic test_full_mask();
        logic [DATA_W-1:0] exp [0:9];
        int n, span, sb; bit to;
        do_reset();
        ch_mask_i = 8'hFF;
        exp[0] = 32'hA5FF0000;
        for (int i = 0; i < 8; i++) exp[i+1] = 32'h100 + i;
        exp[9] = 32'h1234;
        pulse_strobe();
        collect(0, n, span, sb, to);
        checks++; if (to || n != 10) begin failures++; $display("FAIL full_word_count got=%0d timeout=%0d want=10", n, to); end
        checks++; if (span != 10) begin failures++; $display("FAIL full_contiguous cycles got=%0d want=10", span); end
        for (int i = 0; i < 10 && i < n; i++) begin
            checks++;
            if (words[i] !== exp[i] || lasts[i] !== (i == 9)) begin
                failures++;
                $display("FAIL full_word%0d got=%h last=%b want=%h last=%b", i, words[i], lasts[i], exp[i], (i == 9));
            end
        end
        checks++; if (frame_cnt_o !== 16'd1) begin failures++; $display("FAIL full_frame_cnt got=%h want=1", frame_cnt_o); end
        checks++; if (busy_o !== 1'b0 || m_valid_o !== 1'b0) begin failures++; $display("FAIL full_idle_after busy=%b valid=%b want=0,0", busy_o, m_valid_o); end
    endtask

    task automatic test_sparse_stall();
        logic [DATA_W-1:0] exp [0:4];
        int n, span, sb; bit to;
        do_reset();
        ch_mask_i = 8'b0010_0101;
        exp[0] = 32'hA5250000; exp[1] = 32'h100; exp[2] = 32'h102; exp[3] = 32'h105; exp[4] = 32'h1234;
        pulse_strobe();
        ch_mask_i = 8'hFF;
        sync_i    = 32'hDEAD;
        collect(1, n, span, sb, to);
        checks++; if (to || n != 5) begin failures++; $display("FAIL sparse_word_count got=%0d timeout=%0d want=5", n, to); end
        checks++; if (sb != 0) begin failures++; $display("FAIL sparse_stall_stable violations got=%0d want=0", sb); end
        for (int i = 0; i < 5 && i < n; i++) begin
            checks++;
            if (words[i] !== exp[i] || lasts[i] !== (i == 4)) begin
                failures++;
                $display("FAIL sparse_word%0d got=%h last=%b want=%h last=%b", i, words[i], lasts[i], exp[i], (i == 4));
            end
        end
    endtask

    task automatic test_zero_mask();
        int n, span, sb; bit to;
        do_reset();
        ch_mask_i = 8'h00;
        pulse_strobe();
        collect(0, n, span, sb, to);
        checks++; if (to || n != 2) begin failures++; $display("FAIL zero_word_count got=%0d timeout=%0d want=2", n, to); end
        checks++; if (words[0] !== 32'hA5000000 || lasts[0] !== 1'b0) begin failures++; $display("FAIL zero_header got=%h last=%b want=a5000000 last=0", words[0], lasts[0]); end
        checks++; if (words[1] !== 32'h1234 || lasts[1] !== 1'b1) begin failures++; $display("FAIL zero_sync got=%h last=%b want=00001234 last=1", words[1], lasts[1]); end
    endtask

    task automatic test_enable();
        int n, span, sb; bit to;
        do_reset();
        enable_i = 1'b0;
        pulse_strobe();
        checks++; if (busy_o !== 1'b0 || drop_cnt_o !== 16'd0) begin failures++; $display("FAIL disabled_strobe busy=%b drop=%h want=0,0", busy_o, drop_cnt_o); end
        enable_i  = 1'b1;
        ch_mask_i = 8'b0000_0011;
        pulse_strobe();
        enable_i       = 1'b0;
        sample_valid_i = 1'b1;
        collect(0, n, span, sb, to);
        sample_valid_i = 1'b0;
        checks++; if (to || n != 4 || words[0] !== 32'hA5030000 || words[3] !== 32'h1234) begin
            failures++; $display("FAIL enable_fall_frame n=%0d hdr=%h sync=%h want n=4 hdr=a5030000 sync=00001234", n, words[0], words[3]);
        end
        checks++; if (drop_cnt_o !== 16'd0 || frame_cnt_o !== 16'd1) begin failures++; $display("FAIL enable_fall_counts drop=%h frame=%h want=0,1", drop_cnt_o, frame_cnt_o); end
    endtask

    task automatic test_back_to_back();
        int n, span, sb; bit to;
        do_reset();
        ch_mask_i = 8'hFF;
        pulse_strobe();
        for (int i = 1; i <= 10; i++) begin
            sample_valid_i = (i == 4);
            if (i == 10) begin
                checks++; if (m_last_o !== 1'b1) begin failures++; $display("FAIL b2b_sync_last got=%b want=1", m_last_o); end
                sample_valid_i = 1'b1;
                sync_i         = 32'h5678;
            end
            step();
        end
        sample_valid_i = 1'b0;
        checks++; if (m_valid_o !== 1'b1 || m_data_o !== 32'hA5FF0001 || m_last_o !== 1'b0) begin
            failures++; $display("FAIL b2b_next_header valid=%b data=%h last=%b want 1 a5ff0001 0", m_valid_o, m_data_o, m_last_o);
        end
        checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL b2b_drop_cnt got=%h want=1", drop_cnt_o); end
        checks++; if (frame_cnt_o !== 16'd2) begin failures++; $display("FAIL b2b_frame_cnt got=%h want=2", frame_cnt_o); end
        collect(0, n, span, sb, to);
        checks++; if (to || n != 10 || words[9] !== 32'h5678) begin failures++; $display("FAIL b2b_second_frame n=%0d sync=%h want n=10 sync=00005678", n, words[9]); end
    endtask

    task automatic test_wrap_saturate();
        int hdr_seen = 0;
        int err = 0;
        bit wrap_ok = 1'b0;
        bit to = 1'b1;
        logic [15:0] prev = 16'h0;
        do_reset();
        ch_mask_i      = 8'h00;
        sample_valid_i = 1'b1;
        for (int cyc = 0; cyc < 140000; cyc++) begin
            if (m_valid_o && !m_last_o) begin
                if (m_data_o !== {8'hA5, 8'h00, hdr_seen[15:0]}) err++;
                if (hdr_seen == 1000) begin
                    checks++; if (drop_cnt_o !== 16'd1000) begin failures++; $display("FAIL wrap_drop_midway got=%0d want=1000", drop_cnt_o); end
                end
                if (hdr_seen == 65536) wrap_ok = (prev == 16'hFFFF) && (m_data_o[15:0] == 16'h0000);
                prev = m_data_o[15:0];
                hdr_seen++;
                if (hdr_seen == 65537) begin
                    sample_valid_i = 1'b0;
                    to = 1'b0;
                    break;
                end
            end
            step();
        end
        checks++; if (to) begin failures++; $display("FAIL wrap_timeout headers=%0d want=65537", hdr_seen); end
        checks++; if (err != 0) begin failures++; $display("FAIL wrap_header_numbers bad=%0d want=0", err); end
        checks++; if (!wrap_ok) begin failures++; $display("FAIL wrap_ffff_to_0000 got=0 want=1"); end
        repeat (3) step();
        checks++; if (frame_cnt_o !== 16'd1 || busy_o !== 1'b0) begin failures++; $display("FAIL wrap_frame_cnt got=%h busy=%b want=1,0", frame_cnt_o, busy_o); end
        checks++; if (drop_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_drop_cnt got=%h want=ffff", drop_cnt_o); end
        pulse_strobe();
        m_ready_i      = 1'b0;
        sample_valid_i = 1'b1;
        repeat (4) step();
        sample_valid_i = 1'b0;
        checks++; if (drop_cnt_o !== 16'hFFFF || m_data_o !== 32'hA5000001) begin failures++; $display("FAIL sat_hold drop=%h data=%h want ffff a5000001", drop_cnt_o, m_data_o); end
        m_ready_i = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        ch_mask_i      = 8'hFF;
        sample_valid_i = 1'b1;
        step();
        step();
        sample_valid_i = 1'b0;
        step();
        checks++; if (m_data_o !== 32'h101 || drop_cnt_o !== 16'd1) begin failures++; $display("FAIL midrst_precondition data=%h drop=%h want 00000101 1", m_data_o, drop_cnt_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || busy_o !== 1'b0 || m_data_o !== 32'h0) begin
            failures++; $display("FAIL midrst_outputs valid=%b last=%b busy=%b data=%h want 0 0 0 0", m_valid_o, m_last_o, busy_o, m_data_o);
        end
        checks++; if (frame_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin failures++; $display("FAIL midrst_counters frame=%h drop=%h want 0 0", frame_cnt_o, drop_cnt_o); end
        #2 rst_ni = 1'b1;
        step();
        ch_mask_i = 8'h0F;
        pulse_strobe();
        checks++; if (m_valid_o !== 1'b1 || m_data_o !== 32'hA50F0000) begin failures++; $display("FAIL midrst_new_header valid=%b data=%h want 1 a50f0000", m_valid_o, m_data_o); end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_stall();
        test_zero_mask();
        test_enable();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
